// File: rtl/fu_br_q_pkg.sv
// Shared branch-unit types: opcode encoding, index widths and the ROB age helper.
package fu_br_q_pkg;

    localparam int unsigned ARCH_IDX_W = 5;
    localparam int unsigned PHY_IDX_W  = 6;

    typedef enum logic [3:0] {
        BR_BEQ   = 4'd0,
        BR_BNE   = 4'd1,
        BR_BLT   = 4'd2,
        BR_BGE   = 4'd3,
        BR_BLTU  = 4'd4,
        BR_BGEU  = 4'd5,
        BR_JAL   = 4'd6,
        BR_JALR  = 4'd7,
        BR_AUIPC = 4'd8
    } br_op_e;

    // True when x is strictly younger than ref_id, ages measured from head modulo 2^w.
    function automatic logic rob_younger(input logic [31:0] x, input logic [31:0] ref_id,
                                         input logic [31:0] head, input int unsigned w);
        logic [31:0] mask;
        logic [31:0] age_x;
        logic [31:0] age_r;
        mask  = (32'd1 << w) - 32'd1;
        age_x = (x - head) & mask;
        age_r = (ref_id - head) & mask;
        return age_x > age_r;
    endfunction

endpackage

// File: rtl/fu_br_res_q.sv
// Generic circular result queue with per-entry live bits and an external kill mask.
module fu_br_res_q #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned KEY_LSB = 0,
    parameter int unsigned KEY_W   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     push_live,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic [DEPTH-1:0]         kill_mask,
    output logic [W-1:0]             head_data,
    output logic                     head_live,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [DEPTH*KEY_W-1:0]   ent_key
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        live_d  = live_q & ~kill_mask;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            mem_d[tail_q]  = push_data;
            live_d[tail_q] = push_live;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        ent_key = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_key[i*KEY_W +: KEY_W] = mem_q[i][KEY_LSB +: KEY_W];
        end
    end

    assign head_data = mem_q[head_q];
    assign head_live = live_q[head_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fu_br_q.sv
// Branch functional unit: one execute register, combinational resolve, flush-aware result queue.
module fu_br_q
    import fu_br_q_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [3:0]            issue_opcode,
    input  logic [XLEN-1:0]       issue_pc,
    input  logic [XLEN-1:0]       issue_rs1_value,
    input  logic [XLEN-1:0]       issue_rs2_value,
    input  logic [XLEN-1:0]       issue_imm,
    input  logic                  issue_predict_taken,
    input  logic [XLEN-1:0]       issue_predict_target,
    input  logic [ROB_IDX_W-1:0]  issue_rob_id,
    input  logic [ARCH_IDX_W-1:0] issue_rd_arch,
    input  logic [PHY_IDX_W-1:0]  issue_rd_phy,
    input  logic                  cdb_ready,
    output logic                  cdb_valid,
    output logic [ROB_IDX_W-1:0]  cdb_rob_id,
    output logic [PHY_IDX_W-1:0]  cdb_rd_phy,
    output logic [ARCH_IDX_W-1:0] cdb_rd_arch,
    output logic [XLEN-1:0]       cdb_rd_value,
    output logic [XLEN-1:0]       cdb_rs1_value_dbg,
    output logic [XLEN-1:0]       cdb_rs2_value_dbg,
    output logic                  br_cdb_valid,
    output logic [ROB_IDX_W-1:0]  br_cdb_rob_id,
    output logic                  br_cdb_miss_predict,
    output logic [XLEN-1:0]       br_cdb_target_address,
    output logic                  br_cdb_branch_taken,
    input  logic                  flush_valid,
    input  logic [ROB_IDX_W-1:0]  flush_rob_id,
    input  logic [ROB_IDX_W-1:0]  rob_head
);

    typedef struct packed {
        logic [3:0]            opcode;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [XLEN-1:0]       imm;
        logic                  predict_taken;
        logic [XLEN-1:0]       predict_target;
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [PHY_IDX_W-1:0]  rd_phy;
    } fu_br_reg_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [PHY_IDX_W-1:0]  rd_phy;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [XLEN-1:0]       rd_value;
        logic [XLEN-1:0]       rs1_value_dbg;
        logic [XLEN-1:0]       rs2_value_dbg;
        logic                  miss_predict;
        logic [XLEN-1:0]       target_address;
        logic                  branch_taken;
        logic                  is_auipc;
    } fu_br_res_t;

    localparam int unsigned RES_W = $bits(fu_br_res_t);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fu_br_reg_t e_q, e_d;
    logic       e_valid_q, e_valid_d;
    logic       rdy_q, rdy_d;

    fu_br_res_t res;
    fu_br_res_t head;
    logic [RES_W-1:0]           head_bits;
    logic                       head_live;
    logic [CNT_W-1:0]           q_count;
    logic                       q_full;
    logic [DEPTH*ROB_IDX_W-1:0] ent_key;
    logic [DEPTH-1:0]           kill_mask;
    logic                       head_kill, head_alive, pop;
    logic                       e_kill, e_move, issue_kill, load;

    // Resolve from the E register.
    always_comb begin
        logic [XLEN-1:0] pc_imm, pc4, jalr_tgt, target;
        logic            taken, is_branch;
        pc_imm    = e_q.pc + e_q.imm;
        pc4       = e_q.pc + XLEN'(4);
        jalr_tgt  = (e_q.rs1 + e_q.imm) & ~XLEN'(1);
        taken     = 1'b0;
        is_branch = 1'b1;
        case (e_q.opcode)
            BR_BEQ:  taken = (e_q.rs1 == e_q.rs2);
            BR_BNE:  taken = (e_q.rs1 != e_q.rs2);
            BR_BLT:  taken = ($signed(e_q.rs1) <  $signed(e_q.rs2));
            BR_BGE:  taken = ($signed(e_q.rs1) >= $signed(e_q.rs2));
            BR_BLTU: taken = (e_q.rs1 <  e_q.rs2);
            BR_BGEU: taken = (e_q.rs1 >= e_q.rs2);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: is_branch = 1'b0;
        endcase
        target = pc4;
        if (taken) begin
            target = (e_q.opcode == BR_JALR) ? jalr_tgt : pc_imm;
        end
        res.rob_id         = e_q.rob_id;
        res.rd_phy         = e_q.rd_phy;
        res.rd_arch        = e_q.rd_arch;
        res.rd_value       = (e_q.opcode == BR_AUIPC) ? pc_imm : pc4;
        res.rs1_value_dbg  = e_q.rs1;
        res.rs2_value_dbg  = e_q.rs2;
        res.miss_predict   = is_branch &&
                             ((taken != e_q.predict_taken) || (target != e_q.predict_target));
        res.target_address = target;
        res.branch_taken   = taken;
        res.is_auipc       = (e_q.opcode == BR_AUIPC);
    end

    always_comb begin
        kill_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_mask[i] = flush_valid &&
                rob_younger(32'(ent_key[i*ROB_IDX_W +: ROB_IDX_W]), 32'(flush_rob_id),
                            32'(rob_head), ROB_IDX_W);
        end
    end

    assign head       = fu_br_res_t'(head_bits);
    assign head_kill  = flush_valid &&
                        rob_younger(32'(head.rob_id), 32'(flush_rob_id), 32'(rob_head), ROB_IDX_W);
    assign head_alive = (q_count != '0) && head_live && !head_kill;
    assign pop        = (q_count != '0) && (!head_alive || cdb_ready);

    // A killed E entry still moves into Q, just dead, so issue_ready never sees flush.
    assign e_kill      = flush_valid &&
                         rob_younger(32'(e_q.rob_id), 32'(flush_rob_id), 32'(rob_head), ROB_IDX_W);
    assign e_move      = e_valid_q && (!q_full || pop);
    assign issue_ready = rdy_q && (!e_valid_q || e_move);
    assign issue_kill  = flush_valid &&
                         rob_younger(32'(issue_rob_id), 32'(flush_rob_id), 32'(rob_head), ROB_IDX_W);
    assign load        = issue_valid && issue_ready && !issue_kill;

    always_comb begin
        e_d       = e_q;
        e_valid_d = e_valid_q;
        rdy_d     = 1'b1;
        if (load) begin
            e_valid_d        = 1'b1;
            e_d.opcode       = issue_opcode;
            e_d.pc           = issue_pc;
            e_d.rs1          = issue_rs1_value;
            e_d.rs2          = issue_rs2_value;
            e_d.imm          = issue_imm;
            e_d.predict_taken  = issue_predict_taken;
            e_d.predict_target = issue_predict_target;
            e_d.rob_id       = issue_rob_id;
            e_d.rd_arch      = issue_rd_arch;
            e_d.rd_phy       = issue_rd_phy;
        end else if (e_move || e_kill) begin
            e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            e_valid_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            e_q       <= e_d;
            e_valid_q <= e_valid_d;
            rdy_q     <= rdy_d;
        end
    end

    fu_br_res_q #(
        .W       (RES_W),
        .DEPTH   (DEPTH),
        .KEY_LSB (RES_W - ROB_IDX_W),
        .KEY_W   (ROB_IDX_W)
    ) u_res_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (e_move),
        .push_live (!e_kill),
        .push_data (res),
        .pop       (pop),
        .kill_mask (kill_mask),
        .head_data (head_bits),
        .head_live (head_live),
        .count     (q_count),
        .full      (q_full),
        .ent_key   (ent_key)
    );

    assign cdb_valid             = head_alive;
    assign cdb_rob_id            = head.rob_id;
    assign cdb_rd_phy            = head.rd_phy;
    assign cdb_rd_arch           = head.rd_arch;
    assign cdb_rd_value          = head.rd_value;
    assign cdb_rs1_value_dbg     = head.rs1_value_dbg;
    assign cdb_rs2_value_dbg     = head.rs2_value_dbg;
    assign br_cdb_valid          = head_alive && !head.is_auipc;
    assign br_cdb_rob_id         = head.rob_id;
    assign br_cdb_miss_predict   = head.miss_predict;
    assign br_cdb_target_address = head.target_address;
    assign br_cdb_branch_taken   = head.branch_taken;

endmodule
